vga_scanout: RTL and testbench
==============================

# vga_scanout

Frame-buffer reader and VGA timing generator. It is the read-side counterpart of the controller that writes 3-bit pixels into the 160x120 VGA frame buffer. The block sweeps standard 640x480@60 Hz raster timing and fetches one buffer pixel per 4x4 screen block. It drives sync, blanking and 8-bit-per-channel colour to the DAC/connector.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per pixel tick (50 MHz clk gives 25 MHz pixels); must be ≥1.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing, in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing, in lines.
- SCALE_SHIFT, 2: screen-to-buffer downscale, log2 (4x4 blocks).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rd_x_addr  out  8  buffer column, h_cnt>>SCALE_SHIFT.
- rd_y_addr  out  7  buffer row, v_cnt>>SCALE_SHIFT.
- rd_en  out  1  buffer read strobe, one clk wide.
- rd_data  in  3  buffer pixel {r,g,b}, valid the clk after rd_en and held until the next read.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_r / vga_g / vga_b  out  8 each  colour channels.
- vga_blank_n  out  1  high during active video.
- frame_start  out  1  one-clk pulse when output pixel (0,0) is presented.
- vblank  out  1  high while output v_cnt ≥ V_ACTIVE; the writer may update the buffer tear-free in this window.

## Operation
- A divider counts 0..CLK_DIV-1. The pixel tick is asserted when the divider is 0.
- Raster counters update on each tick:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL=800.
  - On the h wrap, v_cnt counts 0..V_TOTAL-1, where V_TOTAL=525.
  - On the wrap 524→0, both counters return to 0 together.
- Active region: h_cnt<640 and v_cnt<480.
- Fetch stage:
  - On a tick with the counters in the active region, drive rd_en=1 for that clk, with rd_x_addr/rd_y_addr derived from the counters.
  - Outside the active region, rd_en=0 and the addresses hold.
- Output stage registers on the next tick, one pixel tick behind the counters:
  - hs=0 iff h∈[656,751].
  - vs=0 iff v∈[490,491].
  - blank_n = active.
  - If active, each channel = {8{rd_data bit}}: vga_r←bit2, vga_g←bit1, vga_b←bit0. Otherwise all channels are 0.
- frame_start asserts on the clk the output stage presents (0,0).
- No other state machine: the block is a free-running counter plus a two-stage pipeline.

## Timing
- Reset values (next clk after rst=1):
  - Divider, h_cnt and v_cnt = 0.
  - rd_en=0; rd_x_addr=0; rd_y_addr=0.
  - vga_hs=1; vga_vs=1.
  - RGB=0; vga_blank_n=0.
  - frame_start=0; vblank=0.
- First tick: the first clk with rst=0.
- Latency: colour, sync and blank for counter position P appear exactly one pixel tick (CLK_DIV clks) after rd_en for P. Sync is delayed identically, so sync, blank and colour stay aligned.
- Line period: 800 ticks. Frame period: 420000 ticks = 840000 clks at CLK_DIV=2.
- Each buffer address is held for 4 consecutive ticks. The same row is read on 4 consecutive lines.
- Address ranges: rd_x_addr reaches at most 159 and rd_y_addr at most 119. Address arithmetic is truncated shifts with no rounding.
- Reset mid-frame: the raster restarts at (0,0) and the in-flight pixel is discarded. The first frame_start follows one tick after the first post-reset tick.
- rd_data is sampled only on ticks; its value between ticks is ignored.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1: rd_en is forced to 0, and the active-pixel colour = h_cnt[9:7] ^ v_cnt[8:6], treated as {r,g,b}.
  - Sync, blank and latency are unchanged.
- Not defined: the port is absent and colour always comes from rd_data.

## Test plan
- Line timing: release rst, CLK_DIV=2 → vga_hs falls at tick 657 after the first tick and rises 96 ticks later. The next hs fall is 1600 clks after the first.
- Frame timing → vga_vs is low for exactly 1600 ticks (lines 490-491 at output); frame_start pulses once per 840000 clks; vblank is high for 45 lines.
- Addressing: at h_cnt=4..7, v_cnt=8 → rd_x_addr=1, rd_y_addr=2, with rd_en=1 on each tick. With rd_data=3'b101 returned, the next tick gives vga_r=8'hFF, vga_g=8'h00, vga_b=8'hFF, vga_blank_n=1.
- Blanking: rd_data held at 3'b111 while h_cnt=640..799 → rd_en=0, RGB=0, vga_blank_n=0 on those output ticks.
- Mid-frame reset: assert rst at h=300, v=200 → the next clk shows all reset values. After release, the raster restarts at (0,0), with frame_start 1 tick after the first post-reset tick.
- With VGA_TEST_PATTERN_EN, test_mode=1 → rd_en never asserts; output pixel h=128, v=0 has colour 3'b001 (vga_b=8'hFF only).

Source files
------------

// File: rtl/vga_scanout.sv
// VGA raster timing generator and frame-buffer reader (one buffer pixel per 2^SCALE_SHIFT square).
// Optional feature: define VGA_TEST_PATTERN_EN to add test_mode and a built-in colour pattern.
module vga_scanout #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    output logic [7:0] rd_x_addr,
    output logic [6:0] rd_y_addr,
    output logic       rd_en,
    input  logic [2:0] rd_data,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_blank_n,
    output logic       frame_start,
    output logic       vblank
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] p_h;
    logic [VW-1:0] p_v;
    logic          p_act;
    logic          p_vld;
    logic          tick_c;
    logic          active_c;
    logic          fetch_c;
    logic [2:0]    pix_c;

    assign tick_c   = (div == '0);
    assign active_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
    assign fetch_c = active_c && !test_mode;
    assign pix_c   = test_mode ? (3'(p_h >> 7) ^ 3'(p_v >> 6)) : rd_data;
`else
    assign fetch_c = active_c;
    assign pix_c   = rd_data;
`endif

    // Pixel-tick divider.
    always_ff @(posedge clk) begin
        if (rst || div == DIV_LAST) div <= '0;
        else                        div <= div + DW'(1);
    end

    // Free-running raster position of the pixel being fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick_c) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Fetch stage: issue the buffer read and carry the position to the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en     <= 1'b0;
            rd_x_addr <= '0;
            rd_y_addr <= '0;
            p_h       <= '0;
            p_v       <= '0;
            p_act     <= 1'b0;
            p_vld     <= 1'b0;
        end else begin
            rd_en <= tick_c && fetch_c;
            if (tick_c) begin
                if (active_c) begin
                    rd_x_addr <= 8'(h_cnt >> SCALE_SHIFT);
                    rd_y_addr <= 7'(v_cnt >> SCALE_SHIFT);
                end
                p_h   <= h_cnt;
                p_v   <= v_cnt;
                p_act <= active_c;
                p_vld <= 1'b1;
            end
        end
    end

    // Output stage: p_vld keeps reset values until a real fetch has been made.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick_c && p_vld) begin
                vga_hs      <= !((p_h >= HS_BEG) && (p_h <= HS_END));
                vga_vs      <= !((p_v >= VS_BEG) && (p_v <= VS_END));
                vga_blank_n <= p_act;
                vga_r       <= p_act ? {8{pix_c[2]}} : 8'h00;
                vga_g       <= p_act ? {8{pix_c[1]}} : 8'h00;
                vga_b       <= p_act ? {8{pix_c[0]}} : 8'h00;
                frame_start <= (p_h == '0) && (p_v == '0);
                vblank      <= (p_v >= V_ACT);
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout: reduced raster geometry, frame-buffer model and position-based reference.
module tb_vga_scanout;
    localparam int CLK_DIV = 2;
    localparam int HA = 32, HF = 4, HS = 8, HB = 4;
    localparam int VA = 24, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int SH = 2;
    localparam int BW = HA >> SH;
    localparam int BH = VA >> SH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rd_data = 3'b000;
    logic [7:0] rd_x_addr;
    logic [6:0] rd_y_addr;
    logic       rd_en, vga_hs, vga_vs, vga_blank_n, frame_start, vblank;
    logic [7:0] vga_r, vga_g, vga_b;

    always #5 clk = ~clk;

    vga_scanout #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SCALE_SHIFT(SH)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(1'b0),
`endif
        .rd_x_addr(rd_x_addr),
        .rd_y_addr(rd_y_addr),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .vga_blank_n(vga_blank_n),
        .frame_start(frame_start),
        .vblank(vblank)
    );

    typedef struct packed {
        logic       rd_en;
        logic [7:0] x;
        logic [6:0] y;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank_n;
        logic       fs;
        logic       vblank;
    } obs_t;

    typedef struct {
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic bl;
        logic vb;
        logic fs;
    } vec_t;

    logic [2:0] mem [0:BH-1][0:BW-1];
    int   n_vec = 0;
    int   n_bad = 0;
    int   c = -1;
    int   ex_x = 0;
    int   ex_y = 0;
    bit   seg0 = 1'b1;
    logic hs_prev = 1'b1;
    int   falls[$];
    vec_t tbl[13];

    function automatic bit act(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (clk %0d after release)", name, got, exp_v, c);
        end
    endtask

    task automatic fill_mem();
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                mem[y][x] = 3'($urandom);
        mem[2][1] = 3'b101;
    endtask

    // Expected outputs after the c-th clock since reset release (c<0: in reset).
    function automatic obs_t model_obs();
        obs_t e;
        int k, h, v, qh, qv;
        bit tk;
        logic [2:0] col;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.x = 8'(ex_x);
        e.y = 7'(ex_y);
        if (c < 0) return e;
        k  = c / CLK_DIV;
        tk = (c % CLK_DIV) == 0;
        h  = k % HT;
        v  = (k / HT) % VT;
        e.rd_en = tk && act(h, v);
        if (k > 0) begin
            qh = (k - 1) % HT;
            qv = ((k - 1) / HT) % VT;
            col = act(qh, qv) ? mem[qv >> SH][qh >> SH] : 3'b000;
            e.hs      = !(qh >= HA + HF && qh < HA + HF + HS);
            e.vs      = !(qv >= VA + VF && qv < VA + VF + VS);
            e.blank_n = act(qh, qv);
            e.r       = {8{col[2]}};
            e.g       = {8{col[1]}};
            e.b       = {8{col[0]}};
            e.fs      = tk && qh == 0 && qv == 0;
            e.vblank  = qv >= VA;
        end
        return e;
    endfunction

    // One clock: advance the model, check every output, then act as the frame buffer.
    task automatic step();
        obs_t got, exp_o;
        int k, h, v, xi, yi;
        bit tk;
        @(posedge clk);
        tk = 1'b0;
        h  = 0;
        if (rst) begin
            if (c >= 0) seg0 = 1'b0;
            c = -1;
            ex_x = 0;
            ex_y = 0;
        end else begin
            c++;
            k  = c / CLK_DIV;
            tk = (c % CLK_DIV) == 0;
            h  = k % HT;
            v  = (k / HT) % VT;
            if (tk && act(h, v)) begin
                ex_x = h >> SH;
                ex_y = v >> SH;
            end
            if (tk && h == 0 && v == VA) fill_mem();
        end
        @(negedge clk);
        got = {rd_en, rd_x_addr, rd_y_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b,
               vga_blank_n, frame_start, vblank};
        exp_o = model_obs();
        cmp("clk_outputs", 64'(got), 64'(exp_o));
        if (seg0 && c >= 0 && hs_prev === 1'b1 && vga_hs === 1'b0) falls.push_back(c);
        hs_prev = vga_hs;
        if (rd_en === 1'b1) begin
            xi = int'(rd_x_addr);
            yi = int'(rd_y_addr);
            rd_data = (xi < BW && yi < BH) ? mem[yi][xi] : 3'b000;
        end else if (tk) begin
            rd_data = (h >= HA) ? 3'b111 : 3'($urandom);
        end
    endtask

    // Advance until the output stage presents raster position (h,v).
    task automatic run_to(input int h, input int v);
        int qk;
        for (int i = 0; i < HT * VT * CLK_DIV + 8; i++) begin
            step();
            qk = c / CLK_DIV - 1;
            if (c >= CLK_DIV && (c % CLK_DIV) == 0 && qk % HT == h && (qk / HT) % VT == v) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL run_to_timeout: output (%0d,%0d) never reached", h, v);
    endtask

    // Advance until the fetch stage is reading raster position (h,v).
    task automatic run_fetch_to(input int h, input int v);
        int k;
        for (int i = 0; i < HT * VT * CLK_DIV + 8; i++) begin
            step();
            k = c / CLK_DIV;
            if (c >= 0 && (c % CLK_DIV) == 0 && k % HT == h && (k / HT) % VT == v) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL fetch_timeout: fetch (%0d,%0d) never reached", h, v);
    endtask

    initial begin
        tbl[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{31, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{35, 5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{36, 5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{43, 5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{44, 5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{10, 23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{10, 24, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{0,  26, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{40, 28, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{0,  29, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{47, 31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        fill_mem();

        // Reset state.
        repeat (3) step();
        cmp("reset_values",
            64'({rd_en, rd_x_addr, rd_y_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, frame_start, vblank}),
            64'({1'b0, 8'd0, 7'd0, 1'b1, 1'b1, 24'd0, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;

        // Sync/blank/vblank/frame_start at chosen raster positions.
        for (int i = 0; i < 13; i++) begin
            run_to(tbl[i].h, tbl[i].v);
            cmp($sformatf("tbl_%0d_%0d", tbl[i].h, tbl[i].v),
                64'({vga_hs, vga_vs, vga_blank_n, vblank, frame_start}),
                64'({tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].vb, tbl[i].fs}));
        end

        // Line timing: first hs fall and line period.
        cmp("hs_fall_count_ok", 64'(falls.size() >= 2), 64'(1));
        if (falls.size() >= 2) begin
            cmp("hs_first_fall_clk", 64'(falls[0]), 64'((HA + HF + 1) * CLK_DIV));
            cmp("hs_line_period", 64'(falls[1] - falls[0]), 64'(HT * CLK_DIV));
        end

        // Addressing: h=4..7 on line 8 all read buffer (1,2); that cell holds 3'b101.
        run_fetch_to(4, 8);
        for (int i = 0; i < 4; i++) begin
            cmp("addr_fetch", 64'({rd_en, rd_x_addr, rd_y_addr}), 64'({1'b1, 8'd1, 7'd2}));
            if (i > 0)
                cmp("addr_colour", 64'({vga_r, vga_g, vga_b, vga_blank_n}), 64'({8'hFF, 8'h00, 8'hFF, 1'b1}));
            repeat (CLK_DIV) step();
        end

        // Mid-frame reset.
        run_to(20, 10);
        rst = 1'b1;
        step();
        cmp("midframe_reset",
            64'({rd_en, rd_x_addr, rd_y_addr, vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, frame_start, vblank}),
            64'({1'b0, 8'd0, 7'd0, 1'b1, 1'b1, 24'd0, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        step();
        cmp("restart_fetch00", 64'({rd_en, rd_x_addr, rd_y_addr}), 64'({1'b1, 8'd0, 7'd0}));
        repeat (CLK_DIV) step();
        cmp("restart_frame_start", 64'(frame_start), 64'(1));

        // Random run with random frame-buffer contents and occasional resets.
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(200, 2500)) step();
            if ($urandom_range(0, 1) == 1) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b0;
            end
        end
        repeat (HT * VT * CLK_DIV + 100) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
